// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   Single-port word memory behind a three-state access controller
//   (IDLE -> ACCESS -> DONE). Each request captured in IDLE takes a
//   programmable number of wait states. The upstream pipeline is held with
//   'stall' until the access completes.
//
// Parameters
//   DATA_WIDTH  : word width of the array and the data ports
//   ADDR_WIDTH  : word address width; depth is 2**ADDR_WIDTH
//   WAIT_STATES : ACCESS cycles per access, 0..15
//
// Ports
//   clk      : rising-edge clock
//   rst      : synchronous active-low reset
//   cs       : request strobe from the address decoder
//   we       : 1 = write, 0 = read (qualified by cs)
//   address  : word address
//   data_in  : store data
//   data_out : registered load data, held until the next read completes
//   ready    : one-cycle completion pulse (DONE state)
//   stall    : combinational pipeline hold request
module data_memory_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  stall
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              count;
    logic [3:0]              count_next;

    logic                    lat_we;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_data;

    logic                    commit;
    logic                    op_we;
    logic [ADDR_WIDTH-1:0]   op_addr;
    logic [DATA_WIDTH-1:0]   op_data;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // State register and wait counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Request capture: once latched, later input activity cannot disturb the access
    always_ff @(posedge clk) begin
        if (state == IDLE && cs) begin
            lat_we   <= we;
            lat_addr <= address;
            lat_data <= data_in;
        end
    end

    // Next state, stall, and the edge on which the memory operation lands.
    // With zero wait states the operation lands on the capture edge itself,
    // so the live inputs are used instead of the (not yet loaded) latches.
    always_comb begin
        state_next = state;
        count_next = count;
        stall      = 1'b0;
        commit     = 1'b0;
        op_we      = lat_we;
        op_addr    = lat_addr;
        op_data    = lat_data;
        unique case (state)
            IDLE: begin
                if (cs) begin
                    stall      = 1'b1;
                    count_next = CNT_LOAD;
                    op_we      = we;
                    op_addr    = address;
                    op_data    = data_in;
                    if (WAIT_STATES == 0) begin
                        state_next = DONE;
                        commit     = 1'b1;
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (count == 4'd0) begin
                    state_next = DONE;
                    commit     = 1'b1;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // A reset edge abandons whatever was about to complete
        if (!rst) begin
            stall  = 1'b0;
            commit = 1'b0;
        end
    end

    // Storage array: never cleared by reset
    always_ff @(posedge clk) begin
        if (commit && op_we) begin
            mem[op_addr] <= op_data;
        end
    end

    // Load data register
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out <= '0;
        end else if (commit && !op_we) begin
            data_out <= mem[op_addr];
        end
    end

    assign ready = (state == DONE);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl
//   Drives two controllers (WAIT_STATES=0 and WAIT_STATES=2) side by side and
//   compares stall, ready and data_out every cycle against a transaction-level
//   model: a countdown of remaining cycles per access plus a plain array for
//   the memory contents.
module tb_data_memory_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT pins (driven only on the falling edge)
    logic          rst;
    logic          cs0, we0, cs1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, din1;
    logic [DW-1:0] dout0, dout1;
    logic          rdy0, rdy1, stl0, stl1;

    data_memory_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .cs(cs0), .we(we0), .address(addr0), .data_in(din0),
        .data_out(dout0), .ready(rdy0), .stall(stl0)
    );

    data_memory_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .cs(cs1), .we(we1), .address(addr1), .data_in(din1),
        .data_out(dout1), .ready(rdy1), .stall(stl1)
    );

    // Staged stimulus, index 0 -> u_ws0, index 1 -> u_ws2
    bit            s_rst;
    bit            s_cs   [2];
    bit            s_we   [2];
    logic [AW-1:0] s_addr [2];
    logic [DW-1:0] s_din  [2];

    // Reference model
    int            ws_of  [2] = '{0, 2};
    bit            m_busy [2];
    bit            m_done [2];
    int            m_left [2];
    bit            m_we   [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_din  [2];
    logic [DW-1:0] m_dout [2];
    logic [DW-1:0] m_mem  [2][1024];
    bit            known;

    logic [AW-1:0] pool [9] = '{10'h000, 10'h001, 10'h002, 10'h004, 10'h010,
                                10'h020, 10'h100, 10'h3FE, 10'h3FF};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic perform(input int i);
        if (m_we[i]) m_mem[i][m_addr[i]] = m_din[i];
        else         m_dout[i] = m_mem[i][m_addr[i]];
    endtask

    // Effect of one rising edge on the model of instance i
    task automatic model_edge(input int i);
        if (!s_rst) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
            m_dout[i] = '0;
        end else if (m_done[i]) begin
            m_done[i] = 1'b0;
        end else if (m_busy[i]) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
                perform(i);
                m_busy[i] = 1'b0;
                m_done[i] = 1'b1;
            end
        end else if (s_cs[i]) begin
            m_we[i]   = s_we[i];
            m_addr[i] = s_addr[i];
            m_din[i]  = s_din[i];
            if (ws_of[i] == 0) begin
                perform(i);
                m_done[i] = 1'b1;
            end else begin
                m_busy[i] = 1'b1;
                m_left[i] = ws_of[i];
            end
        end
    endtask

    // One clock cycle: apply staged inputs, check outputs, advance the model
    task automatic step();
        logic          a_stl [2];
        logic          a_rdy [2];
        logic [DW-1:0] a_dout[2];
        @(negedge clk);
        rst   = s_rst;
        cs0   = s_cs[0]; we0 = s_we[0]; addr0 = s_addr[0]; din0 = s_din[0];
        cs1   = s_cs[1]; we1 = s_we[1]; addr1 = s_addr[1]; din1 = s_din[1];
        #1;
        a_stl[0] = stl0; a_rdy[0] = rdy0; a_dout[0] = dout0;
        a_stl[1] = stl1; a_rdy[1] = rdy1; a_dout[1] = dout1;
        if (known) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("ws%0d_stall", ws_of[i]), DW'(a_stl[i]),
                      DW'(s_rst && (m_busy[i] || (!m_done[i] && s_cs[i]))));
                check($sformatf("ws%0d_ready", ws_of[i]), DW'(a_rdy[i]), DW'(m_done[i]));
                check($sformatf("ws%0d_data_out", ws_of[i]), a_dout[i], m_dout[i]);
            end
        end
        @(posedge clk);
        #1;
        model_edge(0);
        model_edge(1);
        if (!s_rst) known = 1'b1;
    endtask

    task automatic idle_all();
        s_cs[0] = 1'b0;
        s_cs[1] = 1'b0;
    endtask

    // One complete access on instance i with cs asserted only in the capture cycle
    task automatic op(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle_all();
        s_cs[i] = 1'b1; s_we[i] = w; s_addr[i] = a; s_din[i] = d;
        step();
        s_cs[i] = 1'b0;
        repeat (3) step();
    endtask

    logic [DW-1:0] pre;

    initial begin
        s_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_cs[i] = 1'b0; s_we[i] = 1'b0; s_addr[i] = '0; s_din[i] = '0;
        end
        repeat (2) step();
        s_rst = 1'b1;
        step();
        check("rst_dout_ws2", dout1, '0);
        check("rst_dout_ws0", dout0, '0);

        // Give every address in the pool a known value in both arrays
        for (int k = 0; k < 9; k++) begin
            op(0, 1'b1, pool[k], $urandom);
            op(1, 1'b1, pool[k], $urandom);
        end

        // Write then read back on the wait-state instance
        pre = dout1;
        op(1, 1'b1, 10'h004, 32'hDEADBEEF);
        check("write_keeps_dout", dout1, pre);
        op(1, 1'b0, 10'h004, '0);
        check("readback_004", dout1, 32'hDEADBEEF);
        repeat (2) step();
        check("readback_held", dout1, 32'hDEADBEEF);

        // Inputs changing after capture are ignored
        pre = m_mem[1][10'h3FF];
        idle_all();
        s_cs[1] = 1'b1; s_we[1] = 1'b1; s_addr[1] = 10'h010; s_din[1] = 32'h11111111;
        step();
        s_addr[1] = 10'h3FF; s_din[1] = 32'h22222222;
        repeat (3) step();
        s_cs[1] = 1'b0;
        step();
        op(1, 1'b0, 10'h010, '0);
        check("capture_010", dout1, 32'h11111111);
        op(1, 1'b0, 10'h3FF, '0);
        check("untouched_3ff", dout1, pre);

        // Reset in the second ACCESS cycle abandons the write
        pre = m_mem[1][10'h020];
        idle_all();
        s_cs[1] = 1'b1; s_we[1] = 1'b1; s_addr[1] = 10'h020; s_din[1] = 32'hCAFEF00D;
        step();
        s_cs[1] = 1'b0;
        step();
        s_rst = 1'b0;
        step();
        s_rst = 1'b1;
        step();
        check("abort_dout", dout1, '0);
        op(1, 1'b0, 10'h020, '0);
        check("abort_mem_020", dout1, pre);

        // cs held high for eight cycles: one access per IDLE entry
        idle_all();
        s_cs[1] = 1'b1; s_we[1] = 1'b0; s_addr[1] = 10'h004;
        repeat (8) step();
        idle_all();
        repeat (2) step();

        // Zero wait states: boundary addresses
        op(0, 1'b1, 10'h3FF, 32'hA5A5A5A5);
        op(0, 1'b0, 10'h3FF, '0);
        check("ws0_read_3ff", dout0, 32'hA5A5A5A5);
        op(0, 1'b0, 10'h000, '0);
        check("ws0_read_000", dout0, m_mem[0][10'h000]);

        // Randomized traffic on both instances, with occasional resets
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                s_cs[i]   = ($urandom_range(0, 3) != 0);
                s_we[i]   = 1'($urandom_range(0, 1));
                s_addr[i] = pool[$urandom_range(0, 8)];
                s_din[i]  = $urandom;
            end
            s_rst = ($urandom_range(0, 49) != 0);
            step();
        end
        s_rst = 1'b1;
        idle_all();
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width of the storage array and data ports.
REQ-002 Parameter ADDR_WIDTH, default 10: word address width; array depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Parameter WAIT_STATES, default 2: number of ACCESS cycles per access; legal range 0..15.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 cs  input  1  chip select from the upstream address decoder; request when high.
REQ-007 we  input  1  write enable from the decoder; 1 = write, 0 = read; qualified by cs.
REQ-008 address  input  ADDR_WIDTH  word address from the decoder.
REQ-009 data_in  input  DATA_WIDTH  store data.
REQ-010 data_out  output  DATA_WIDTH  registered load data.
REQ-011 ready  output  1  one-cycle completion pulse.
REQ-012 stall  output  1  pipeline hold request to the CPU.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE.
REQ-014 In IDLE with cs=1 at an edge, the block SHALL latch address, we and data_in, load the wait counter with WAIT_STATES-1, and go to ACCESS (to DONE when WAIT_STATES=0).
REQ-015 In IDLE with cs=0, the block SHALL stay in IDLE.
REQ-016 In ACCESS, the counter SHALL decrement each cycle; at counter=0 the next state SHALL be DONE.
REQ-017 On the ACCESS->DONE edge (IDLE->DONE when WAIT_STATES=0): a write SHALL commit latched data_in to mem[latched address]; a read SHALL load data_out from mem[latched address].
REQ-018 DONE SHALL last exactly one cycle and SHALL always go to IDLE, ignoring cs.
REQ-019 ready SHALL be 1 only in DONE, for both reads and writes.
REQ-020 stall SHALL be combinational: 1 when (state=IDLE and cs=1) or state=ACCESS; 0 in DONE and whenever rst=0.
REQ-021 Changes on cs, we, address or data_in after capture SHALL NOT affect the access in progress.
REQ-022 data_out SHALL hold its value until the next read completes; writes SHALL NOT change data_out.
REQ-023 Total latency SHALL be WAIT_STATES+1 cycles from the capture edge to the DONE cycle; stall SHALL be high for WAIT_STATES+1 cycles.
REQ-024 Address 0 and address 2**ADDR_WIDTH-1 SHALL be fully accessible; no wrap or aliasing inside the array.
REQ-025 cs held high continuously SHALL produce one access per IDLE entry, with exactly one DONE cycle between accesses.

Reset
REQ-026 With rst=0 at an edge: state SHALL be IDLE, counter 0, data_out 0, ready 0.
REQ-027 Reset during ACCESS SHALL abandon the access: no memory write, no ready pulse, data_out = 0.
REQ-028 Array contents SHALL NOT be cleared by reset.

Verification
REQ-029 Write, WAIT_STATES=2: cs=1, we=1, address=0x004, data_in=0xDEADBEEF at cycle 0 -> stall=1 for cycles 0-2, ready=1 and stall=0 at cycle 3, mem[0x004]=0xDEADBEEF, data_out unchanged.
REQ-030 Read back: cs=1, we=0, address=0x004 -> data_out=0xDEADBEEF in the ready cycle, held after cs drops.
REQ-031 Input change: during ACCESS of a write to 0x010 with 0x11111111, drive address=0x3FF and data_in=0x22222222 -> mem[0x010]=0x11111111 and mem[0x3FF] unchanged.
REQ-032 Reset mid-op: rst=0 in the second ACCESS cycle of a write of 0xCAFEF00D to 0x020 -> no ready pulse, mem[0x020] unchanged, data_out=0, state IDLE.
REQ-033 Back-to-back: cs=1 held for 8 cycles with WAIT_STATES=2 -> ready pulses at cycles 3 and 7; stall=0 at cycles 3 and 7.
REQ-034 WAIT_STATES=0: write 0xA5A5A5A5 to 0x3FF, then read 0x3FF and read 0x000 -> each ready one cycle after capture, stall=1 for one cycle, data_out=0xA5A5A5A5 then mem[0x000].
